// File: rtl/oflow_mem_buffer_ctrl_multi.sv
// Pointer and sequencing controller for the bbox history memory buffer.
// The write side streams the current frame's offsets into a circular history
// slot, LANES entries per cycle. The read side replays the stored frames to the
// similarity metric, newest first, one line per line_ready handshake.
module oflow_mem_buffer_ctrl_multi #(
  parameter int MAX_HIST = 8,
  parameter int MAX_BBOX = 64,
  parameter int LANES    = 2,
  parameter int OFF_W    = $clog2(MAX_BBOX),
  parameter int CNT_W    = $clog2(MAX_BBOX + 1),
  parameter int SLOT_W   = $clog2(MAX_HIST)
) (
  input  logic                     clk,
  input  logic                     reset_N,
  input  logic [SLOT_W:0]          num_hist,
  input  logic [CNT_W-1:0]         num_bbox,
  input  logic                     start_write,
  input  logic                     ready_from_core,
  output logic                     wr_valid,
  output logic [SLOT_W-1:0]        wr_slot,
  output logic [LANES*OFF_W-1:0]   wr_offset,
  output logic [LANES-1:0]         wr_lane_en,
  output logic                     done_write,
  input  logic                     start_read,
  input  logic                     line_ready,
  output logic                     rd_valid,
  output logic [SLOT_W-1:0]        rd_slot,
  output logic [LANES*OFF_W-1:0]   rd_offset,
  output logic [LANES-1:0]         rd_lane_en,
  output logic [SLOT_W-1:0]        rd_hist_idx,
  output logic                     done_read,
  output logic [SLOT_W:0]          valid_frames,
  output logic                     busy
);

  // Base pointers run up to one line past the frame end, so they need headroom.
  localparam int BW = $clog2(MAX_BBOX + 2 * LANES + 1);
  localparam int HW = SLOT_W + 1;

  typedef enum logic [1:0] {W_IDLE, W_RUN, W_DONE} wstate_t;
  typedef enum logic [2:0] {R_IDLE, R_LOAD, R_WAIT, R_ISSUE, R_DONE} rstate_t;

  wstate_t            w_state, w_next;
  rstate_t            r_state, r_next;

  logic [CNT_W-1:0]   end_ptr [MAX_HIST];
  logic [SLOT_W-1:0]  wr_ptr_slot;
  logic [HW-1:0]      vf_q;
  logic [HW-1:0]      nh_q;

  logic [SLOT_W-1:0]  w_slot;
  logic [BW-1:0]      w_base;
  logic [BW-1:0]      w_num;

  logic [HW-1:0]      r_n;
  logic [HW-1:0]      r_h;
  logic [SLOT_W-1:0]  r_slot;
  logic [BW-1:0]      r_base;
  logic [BW-1:0]      r_end;

  logic               w_idle, r_idle, busy_int;
  logic               w_start, r_start, cfg_load;
  logic               w_last, r_line_last, r_h_last, r_skip, r_adv;

  // Wrap increment/decrement of a slot index against the active history depth.
  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s,
                                                 input logic [HW-1:0] nh);
    return ({1'b0, s} == nh - HW'(1)) ? '0 : s + SLOT_W'(1);
  endfunction

  function automatic logic [SLOT_W-1:0] slot_dec(input logic [SLOT_W-1:0] s,
                                                 input logic [HW-1:0] nh);
    return (s == '0) ? SLOT_W'(nh - HW'(1)) : s - SLOT_W'(1);
  endfunction

  assign w_idle      = (w_state == W_IDLE);
  assign r_idle      = (r_state == R_IDLE);
  assign busy_int    = !w_idle || !r_idle;
  assign w_start     = w_idle && start_write;
  assign r_start     = r_idle && start_read;
  assign w_last      = (w_base + BW'(LANES) >= w_num);
  assign r_line_last = (r_base + BW'(LANES) >= r_end);
  assign r_h_last    = (r_h + HW'(1) == r_n);
  assign r_skip      = (r_state == R_LOAD) && (end_ptr[r_slot] == '0);
  assign r_adv       = r_skip || ((r_state == R_ISSUE) && r_line_last);
  // A new depth is only taken while fully idle and not in a start cycle, so the
  // clamp of wr_ptr_slot can never race a slot being latched by a new write.
  assign cfg_load    = !busy_int && !start_write && !start_read && (num_hist != nh_q);

  // Write FSM state register.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write FSM next-state logic.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (start_write) w_next = (num_bbox == '0) ? W_DONE : W_RUN;
      W_RUN:   if (ready_from_core && w_last) w_next = W_DONE;
      W_DONE:  w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write FSM outputs: one line of offsets per accepted cycle.
  always_comb begin
    wr_valid   = (w_state == W_RUN) && ready_from_core;
    wr_slot    = wr_valid ? w_slot : '0;
    wr_offset  = '0;
    wr_lane_en = '0;
    for (int k = 0; k < LANES; k++) begin
      if (wr_valid) begin
        wr_offset[k*OFF_W +: OFF_W] = OFF_W'(w_base + BW'(k));
        wr_lane_en[k]               = (w_base + BW'(k) < w_num);
      end
    end
    done_write = (w_state == W_DONE);
  end

  // Slot bookkeeping: end pointers, write slot pointer, readable frame count, depth.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int i = 0; i < MAX_HIST; i++) end_ptr[i] <= '0;
      wr_ptr_slot <= '0;
      vf_q        <= '0;
      nh_q        <= HW'(MAX_HIST);
    end else begin
      if (w_start) end_ptr[wr_ptr_slot] <= num_bbox;
      if (w_state == W_DONE) begin
        wr_ptr_slot <= slot_inc(wr_ptr_slot, nh_q);
        vf_q        <= (vf_q >= nh_q - HW'(1)) ? nh_q - HW'(1) : vf_q + HW'(1);
      end else if (cfg_load) begin
        nh_q <= num_hist;
        if (num_hist < vf_q + HW'(1)) begin
          vf_q        <= num_hist - HW'(1);
          wr_ptr_slot <= '0;
        end
      end
    end
  end

  // Write datapath: latched slot, frame size and running base offset.
  always_ff @(posedge clk) begin
    if (w_start) begin
      w_slot <= wr_ptr_slot;
      w_num  <= BW'(num_bbox);
      w_base <= '0;
    end else if ((w_state == W_RUN) && ready_from_core) begin
      w_base <= w_base + BW'(LANES);
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read FSM next-state logic.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (start_read) r_next = (vf_q == '0) ? R_DONE : R_LOAD;
      R_LOAD:  if (end_ptr[r_slot] == '0) r_next = r_h_last ? R_DONE : R_LOAD;
               else                       r_next = R_WAIT;
      R_WAIT:  if (line_ready) r_next = R_ISSUE;
      R_ISSUE: if (!r_line_last) r_next = R_WAIT;
               else              r_next = r_h_last ? R_DONE : R_LOAD;
      R_DONE:  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM outputs: a single issue cycle per line.
  always_comb begin
    rd_valid    = (r_state == R_ISSUE);
    rd_slot     = rd_valid ? r_slot : '0;
    rd_hist_idx = rd_valid ? r_h[SLOT_W-1:0] : '0;
    rd_offset   = '0;
    rd_lane_en  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (rd_valid) begin
        rd_offset[k*OFF_W +: OFF_W] = OFF_W'(r_base + BW'(k));
        rd_lane_en[k]               = (r_base + BW'(k) < r_end);
      end
    end
    done_read = (r_state == R_DONE);
  end

  // Read control: frame snapshot and history index.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_n <= '0;
      r_h <= '0;
    end else if (r_start) begin
      r_n <= vf_q;
      r_h <= '0;
    end else if (r_adv) begin
      r_h <= r_h + HW'(1);
    end
  end

  // Read datapath: the newest slot is fixed at start from the pre-write pointer,
  // then walks backwards by wrap decrement as each frame completes.
  always_ff @(posedge clk) begin
    if (r_start) r_slot <= slot_dec(wr_ptr_slot, nh_q);
    else if (r_adv) r_slot <= slot_dec(r_slot, nh_q);
    if (r_state == R_LOAD) begin
      r_base <= '0;
      r_end  <= BW'(end_ptr[r_slot]);
    end else if (r_state == R_ISSUE) begin
      r_base <= r_base + BW'(LANES);
    end
  end

  assign valid_frames = vf_q;
  assign busy         = busy_int;

endmodule
